// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline defaults and IF/ID register type
// Contents:
//   XLEN, RESET_PC, NOP_INST  default datapath width, boot PC and flush filler
//   if_id_t                   IF/ID pipeline register {inst, pc, pc_plus4, valid}
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with clear, occupancy count and flags
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clear             empty the FIFO (wins over push/pop)
//   push, push_data   write one entry
//   pop, pop_data     pop_data always shows the head; pop advances it
//   count             occupancy 0..DEPTH
//   full, empty       occupancy flags
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction fetch with prefetch queue and valid/ready IF/ID register
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      branch/jump/flush target, highest priority
//   imem_req_valid/ready/addr        instruction memory request channel
//   imem_rsp_valid/data              in-order instruction responses
//   id_valid, id_ready               IF/ID handshake towards decode
//   id_inst, id_pc, id_pc_plus4      IF/ID register contents
//   q_count                          prefetch queue occupancy
module if_prefetch_stage #(
  parameter int              XLEN     = rv_pipe_pkg::XLEN,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = rv_pipe_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [XLEN-1:0]           imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [XLEN-1:0]           imem_rsp_data,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [XLEN-1:0]           id_inst,
  output logic [XLEN-1:0]           id_pc,
  output logic [XLEN-1:0]           id_pc_plus4,
  output logic [$clog2(QDEPTH):0]   q_count
);

  import rv_pipe_pkg::if_id_t;

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW:0]       occupancy;
  logic              req_fire;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;
  if_id_t            id_q;

  // Requests in flight plus queued entries never exceed QDEPTH, which is
  // what guarantees every accepted response a queue slot.
  assign occupancy      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = rst && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to a pre-redirect fetch stream are discarded by count.
  assign fifo_push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign fifo_pop  = !redirect_valid && (!id_q.valid || id_ready) && !fifo_empty;

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (q_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle is stale.
      fetch_pc    <= redirect_pc;
      rsp_pc      <= redirect_pc;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (fifo_push) rsp_pc <= rsp_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q <= '0;
    end else if (redirect_valid) begin
      id_q.valid <= 1'b0;
      id_q.inst  <= NOP_INST;
    end else if (fifo_pop) begin
      id_q.valid    <= 1'b1;
      id_q.inst     <= fifo_head[XLEN-1:0];
      id_q.pc       <= fifo_head[2*XLEN-1:XLEN];
      id_q.pc_plus4 <= fifo_head[2*XLEN-1:XLEN] + XLEN'(4);
    end else if (id_q.valid && id_ready) begin
      id_q.valid <= 1'b0;
    end
  end

  assign id_valid    = id_q.valid;
  assign id_inst     = id_q.inst;
  assign id_pc       = id_q.pc;
  assign id_pc_plus4 = id_q.pc_plus4;

  always_ff @(posedge clk) begin
    if (rst && fifo_push) assert (!fifo_full);
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - bench for if_prefetch_stage with memory and stream model
module tb_if_prefetch_stage;

  localparam int          QDEPTH = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [2:0]  q_count;

  if_prefetch_stage #(.QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Memory requests in flight, each tagged with the fetch stream it belongs to.
  req_t mem[$];
  // Instructions fetched but not yet in the IF/ID register.
  ent_t m_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          m_lat    = 1;
  int          rsp_pct  = 100;
  int          m_epoch  = 0;
  logic [31:0] m_fetch;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic        last_req_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    mem.delete();
    m_q.delete();
    m_epoch++;
    m_fetch = 32'h0;
    m_valid = 1'b0;
    m_inst  = 32'h0;
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // request channel, then advance the stream model by the same cycle.
  task automatic run_cycle(input bit redir, input logic [31:0] tgt, input bit idr, input bit reqr);
    bit   rv;
    bit   exp_rv;
    req_t h;
    ent_t e;
    @(negedge clk);
    n_checks++;
    if (id_valid !== m_valid) begin
      n_fail++; $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, m_valid);
    end
    n_checks++;
    if (id_inst !== m_inst) begin
      n_fail++; $display("FAIL id_inst cyc=%0d got=%h exp=%h", cyc, id_inst, m_inst);
    end
    n_checks++;
    if (id_pc !== m_pc) begin
      n_fail++; $display("FAIL id_pc cyc=%0d got=%h exp=%h", cyc, id_pc, m_pc);
    end
    n_checks++;
    if (id_pc_plus4 !== m_pc4) begin
      n_fail++; $display("FAIL id_pc_plus4 cyc=%0d got=%h exp=%h", cyc, id_pc_plus4, m_pc4);
    end
    n_checks++;
    if (q_count !== 3'(m_q.size())) begin
      n_fail++; $display("FAIL q_count cyc=%0d got=%0d exp=%0d", cyc, q_count, m_q.size());
    end
    rv = 1'b0;
    if (mem.size() > 0) begin
      if (mem[0].due <= cyc && $urandom_range(99) < rsp_pct) rv = 1'b1;
    end
    redirect_valid = redir;
    redirect_pc    = tgt;
    id_ready       = idr;
    imem_req_ready = reqr;
    imem_rsp_valid = rv;
    imem_rsp_data  = $urandom();
    if (rv) imem_rsp_data = mem_word(mem[0].addr);
    #1;
    exp_rv = !redir && ((mem.size() + m_q.size()) < QDEPTH);
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    n_checks++;
    if (imem_req_valid !== exp_rv) begin
      n_fail++; $display("FAIL imem_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_checks++;
      if (imem_req_addr !== m_fetch) begin
        n_fail++; $display("FAIL imem_req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch);
      end
    end
    if (redir) begin
      if (rv) void'(mem.pop_front());
      m_epoch++;
      m_q.delete();
      m_valid = 1'b0;
      m_inst  = NOP;
      m_fetch = tgt;
    end else begin
      if ((!m_valid || idr) && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_valid = 1'b1;
        m_inst  = e.inst;
        m_pc    = e.pc;
        m_pc4   = e.pc + 32'd4;
      end else if (m_valid && idr) begin
        m_valid = 1'b0;
      end
      if (rv) begin
        h = mem.pop_front();
        if (h.epoch == m_epoch) m_q.push_back('{pc: h.addr, inst: mem_word(h.addr)});
      end
      if (exp_rv && reqr) begin
        mem.push_back('{addr: m_fetch, epoch: m_epoch, due: cyc + m_lat});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic release_reset();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    n_checks++;
    if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
    n_checks++;
    if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_id_pc got=%h/%h exp=0/0", id_pc, id_pc_plus4);
    end
    n_checks++;
    if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    release_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    int          seen;
    m_lat = 1; rsp_pct = 100;
    exp_pc = 32'h0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (seen > 0 || id_valid) begin
        if (seen < 6) begin
          n_checks++;
          if (id_valid !== 1'b1 || id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4) begin
            n_fail++;
            $display("FAIL seq_pc got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_pc_plus4, exp_pc, exp_pc + 32'd4);
          end
        end
        seen++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    n_checks++;
    if (seen == 0) begin n_fail++; $display("FAIL seq_timeout got=0 exp>0 instructions"); end
  endtask

  task automatic test_stall();
    int          occ0;
    int          fired;
    logic        s_valid;
    logic [31:0] s_inst, s_pc, s_pc4, prev;
    m_lat = 1; rsp_pct = 100;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    occ0  = mem.size() + m_q.size();
    fired = 0;
    run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    if (last_req_valid) fired++;
    s_valid = id_valid; s_inst = id_inst; s_pc = id_pc; s_pc4 = id_pc_plus4;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      else       run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i < 9 && last_req_valid) fired++;
      n_checks++;
      if (id_valid !== s_valid || id_inst !== s_inst || id_pc !== s_pc || id_pc_plus4 !== s_pc4) begin
        n_fail++;
        $display("FAIL stall_hold i=%0d got=%b/%h/%h exp=%b/%h/%h", i, id_valid, id_inst, id_pc, s_valid, s_inst, s_pc);
      end
      if (i == 8) begin
        n_checks++;
        if (last_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_gate got=%b exp=0", last_req_valid); end
      end
    end
    n_checks++;
    if (fired != QDEPTH - occ0) begin n_fail++; $display("FAIL stall_req_count got=%0d exp=%0d", fired, QDEPTH - occ0); end
    n_checks++;
    if (q_count !== 3'(QDEPTH)) begin n_fail++; $display("FAIL stall_q_full got=%0d exp=%0d", q_count, QDEPTH); end
    prev = s_pc;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== prev + 32'd4) begin
        n_fail++; $display("FAIL stall_resume i=%0d got=%b/%h exp=1/%h", i, id_valid, id_pc, prev + 32'd4);
      end
      prev = prev + 32'd4;
    end
  endtask

  task automatic test_redirect_latency();
    int waited;
    bit found;
    m_lat = 3; rsp_pct = 100;
    waited = 0;
    while (mem.size() != 3 && waited < 40) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      waited++;
    end
    n_checks++;
    if (mem.size() != 3) begin n_fail++; $display("FAIL redir_setup got=%0d exp=3 outstanding", mem.size()); end
    run_cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (id_valid) begin
        found = 1'b1;
        n_checks++;
        if (id_pc !== 32'h100 || id_inst !== mem_word(32'h100)) begin
          n_fail++; $display("FAIL redir_first got=%h/%h exp=%h/%h", id_pc, id_inst, 32'h100, mem_word(32'h100));
        end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL redir_timeout got=none exp=id_valid"); end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_redirect_coincident();
    int waited;
    bit due;
    m_lat = 1; rsp_pct = 100;
    waited = 0;
    due = 1'b0;
    while (!due && waited < 40) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      waited++;
      if (mem.size() > 0) due = (mem[0].due <= cyc) && m_valid;
    end
    n_checks++;
    if (!due) begin n_fail++; $display("FAIL coinc_setup got=0 exp=1 pending response"); end
    run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (id_valid !== 1'b0 || id_inst !== NOP) begin
      n_fail++; $display("FAIL coinc_flush got=%b/%h exp=0/%h", id_valid, id_inst, NOP);
    end
    n_checks++;
    if (last_req_valid !== 1'b1 || last_req_addr !== 32'h200) begin
      n_fail++; $display("FAIL coinc_next_req got=%b/%h exp=1/00000200", last_req_valid, last_req_addr);
    end
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[3];
    logic [31:0] p4s[3];
    int          n;
    m_lat = 1; rsp_pct = 100;
    run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i > 0 && id_valid) begin
        pcs[n] = id_pc; p4s[n] = id_pc_plus4; n++;
      end
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL wrap_timeout got=%0d exp=3 instructions", n);
    end else begin
      n_checks++;
      if (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0) begin
        n_fail++; $display("FAIL wrap_pcs got=%h,%h,%h exp=fffffff8,fffffffc,00000000", pcs[0], pcs[1], pcs[2]);
      end
      n_checks++;
      if (p4s[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got=%h exp=00000000", p4s[1]); end
    end
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    bit          redir;
    logic [31:0] tgt;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        m_lat   = $urandom_range(4, 1);
        rsp_pct = $urandom_range(100, 40);
      end
      redir = ($urandom_range(99) < 3);
      tgt   = $urandom() & 32'hFFFF_FFFC;
      run_cycle(redir, tgt, $urandom_range(99) < 70, $urandom_range(99) < 80);
    end
  endtask

  task automatic test_reset_midstream();
    int waited;
    m_lat = 3; rsp_pct = 100;
    waited = 0;
    while (mem.size() == 0 && waited < 20) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      waited++;
    end
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (mem.size() == 0) begin n_fail++; $display("FAIL midrst_setup got=0 exp>0 outstanding"); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL midrst_id got=%b/%h/%h/%h exp=0/0/0/0", id_valid, id_inst, id_pc, id_pc_plus4);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0 || q_count !== 3'd0) begin
      n_fail++; $display("FAIL midrst_req got=%b/%0d exp=0/0", imem_req_valid, q_count);
    end
    model_reset();
    imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (last_req_valid !== 1'b1 || last_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL midrst_restart got=%b/%h exp=1/00000000", last_req_valid, last_req_addr);
    end
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_latency();
    test_redirect_coincident();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
